cpu_instruction_rom_bank: RTL and testbench

//  Parametrised, synchronous-read instruction memory with two banks: user (pc[31]=0)
//  and kernel (pc[31]=1, exception/reset vectors). Replaces hard-coded program tables.
//  A byte-stream loader FSM writes either bank at run time. Misaligned or out-of-range

---
 rtl/cpu_instruction_rom_bank.sv | 188 ++++++++++++++++++
 tb/tb_cpu_instruction_rom_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instruction_rom_bank.sv
// Two-bank instruction memory (user / kernel) with a byte-stream loader.
// Fetches are registered (one-cycle latency). Misaligned or out-of-range pc returns TRAP_WORD.
module cpu_instruction_rom_bank #(
   parameter int unsigned USER_AW    = 7,
   parameter int unsigned KERN_AW    = 5,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
   parameter logic [31:0] TRAP_WORD  = 32'hFFFF_FFFF,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        fetch_en,
   input  logic        stall,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        ld_start,
   input  logic        ld_bank,
   input  logic        ld_byte_valid,
   input  logic [7:0]  ld_byte,
   input  logic        ld_end,
   output logic        ld_busy,
   output logic        ld_done,
   output logic        ld_err,
   output logic [15:0] ld_count
);

   localparam int unsigned USER_DEPTH = 1 << USER_AW;
   localparam int unsigned KERN_DEPTH = 1 << KERN_AW;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOAD = 1'b1;

   logic [31:0] mem_user [USER_DEPTH];
   logic [31:0] mem_kern [KERN_DEPTH];

   logic [0:0]  state_q, state_d;
   logic        bank_q, bank_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [31:0] word_q, word_d;
   logic [15:0] count_q, count_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   logic [31:0] rd_word_c;
   logic        trap_c;
   logic [15:0] cap_c;
   logic [1:0]  lane_c;
   logic        we_c;
   logic [31:0] wdata_c;

   // Fetch address decode and bank read; bad alignment or range yields the trap word
   always_comb begin
      trap_c    = 1'b0;
      rd_word_c = TRAP_WORD;
      if (pc[31]) begin
         trap_c    = (pc[1:0] != 2'd0) || ((pc[30:0] >> (KERN_AW + 2)) != 31'd0);
         rd_word_c = mem_kern[pc[KERN_AW+1:2]];
      end else begin
         trap_c    = (pc[1:0] != 2'd0) || ((pc[30:0] >> (USER_AW + 2)) != 31'd0);
         rd_word_c = mem_user[pc[USER_AW+1:2]];
      end
      if (trap_c) begin
         rd_word_c = TRAP_WORD;
      end
   end

   // Next-state logic for fetch pipeline and loader FSM
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      ptr_d   = ptr_q;
      word_d  = word_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      instr_d = instr_q;
      valid_d = valid_q;
      we_c    = 1'b0;
      wdata_c = word_q;
      cap_c   = bank_q ? 16'(KERN_DEPTH) : 16'(USER_DEPTH);
      lane_c  = BIG_ENDIAN ? (2'd3 - ptr_q) : ptr_q;

      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               // a load start takes precedence over any fetch in the same cycle
               state_d = S_LOAD;
               bank_d  = ld_bank;
               count_d = 16'd0;
               ptr_d   = 2'd0;
               err_d   = 1'b0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               instr_d = NOP_WORD;
               valid_d = 1'b0;
            end else if (!stall) begin
               if (fetch_en) begin
                  instr_d = rd_word_c;
                  valid_d = 1'b1;
               end else begin
                  instr_d = NOP_WORD;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            if (ld_byte_valid) begin
               if (count_q == cap_c) begin
                  err_d = 1'b1;
               end else begin
                  wdata_c[{lane_c, 3'b000} +: 8] = ld_byte;
                  if (ptr_q == 2'd3) begin
                     we_c    = 1'b1;
                     count_d = count_q + 16'd1;
                     ptr_d   = 2'd0;
                  end else begin
                     ptr_d  = ptr_q + 2'd1;
                     word_d = wdata_c;
                  end
               end
            end
            // end is evaluated after any same-cycle byte
            if (ld_end) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (ptr_d != 2'd0) begin
                  err_d = 1'b1;
               end
               ptr_d = 2'd0;
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         bank_q  <= 1'b0;
         ptr_q   <= 2'd0;
         word_q  <= 32'd0;
         count_q <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // Memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (we_c) begin
         if (bank_q) begin
            mem_kern[count_q[KERN_AW-1:0]] <= wdata_c;
         end else begin
            mem_user[count_q[USER_AW-1:0]] <= wdata_c;
         end
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign ld_busy     = busy_q;
   assign ld_done     = done_q;
   assign ld_err      = err_q;
   assign ld_count    = count_q;

endmodule

// File: tb/tb_cpu_instruction_rom_bank.sv
// Testbench for cpu_instruction_rom_bank: directed stimulus, behavioural model, per-cycle compare.
module tb_cpu_instruction_rom_bank;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        fetch_en;
   logic        stall;
   logic [31:0] instr;
   logic        instr_valid;
   logic        ld_start;
   logic        ld_bank;
   logic        ld_byte_valid;
   logic [7:0]  ld_byte;
   logic        ld_end;
   logic        ld_busy;
   logic        ld_done;
   logic        ld_err;
   logic [15:0] ld_count;

   int checks = 0;
   int errors = 0;

   cpu_instruction_rom_bank dut (
      .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall),
      .instr(instr), .instr_valid(instr_valid), .ld_start(ld_start), .ld_bank(ld_bank),
      .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_end(ld_end),
      .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   logic [31:0] mu [128];
   logic [31:0] mk [32];
   bit          ku [128];
   bit          kk [32];
   logic [7:0]  pend [$];
   logic [31:0] m_instr;
   bit          m_valid, m_known, m_busy, m_done, m_err, m_bank;
   int          m_count;

   function automatic int cap_of(input bit b);
      return b ? 32 : 128;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_instr = 32'h0; m_valid = 0; m_known = 1; m_busy = 0; m_done = 0; m_err = 0;
         m_count = 0; pend.delete();
      end else if (!m_busy) begin
         if (ld_start) begin
            m_bank = ld_bank; m_busy = 1; m_count = 0; m_err = 0; m_done = 0; pend.delete();
            m_instr = 32'h0; m_valid = 0; m_known = 1;
         end else if (stall) begin
            // hold
         end else if (fetch_en) begin
            int widx;
            m_valid = 1;
            widx = int'(pc[30:0] / 4);
            if ((pc % 4) != 0 || widx >= cap_of(pc[31])) begin
               m_instr = 32'hFFFF_FFFF; m_known = 1;
            end else if (pc[31]) begin
               m_instr = mk[widx]; m_known = kk[widx];
            end else begin
               m_instr = mu[widx]; m_known = ku[widx];
            end
         end else begin
            m_instr = 32'h0; m_valid = 0; m_known = 1;
         end
      end else begin
         m_instr = 32'h0; m_valid = 0; m_known = 1;
         if (ld_byte_valid) begin
            if (m_count == cap_of(m_bank)) m_err = 1;
            else begin
               pend.push_back(ld_byte);
               if (pend.size() == 4) begin
                  logic [31:0] w;
                  w = {pend[3], pend[2], pend[1], pend[0]};
                  if (m_bank) begin mk[m_count] = w; kk[m_count] = 1; end
                  else begin mu[m_count] = w; ku[m_count] = 1; end
                  m_count++;
                  pend.delete();
               end
            end
         end
         if (ld_end) begin
            if (pend.size() != 0) m_err = 1;
            pend.delete();
            m_busy = 0; m_done = 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #2;
      if (reset) begin
         chk("valid", 32'(instr_valid), 32'(m_valid));
         if (!m_valid || m_known) chk("instr", instr, m_instr);
         chk("busy", 32'(ld_busy), 32'(m_busy));
         chk("done", 32'(ld_done), 32'(m_done));
         chk("err", 32'(ld_err), 32'(m_err));
         chk("count", 32'(ld_count), 32'(m_count));
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] stim [$];

   task automatic tick;
      @(posedge clk);
      #3;
   endtask

   task automatic load(input bit bank, input bit end_with_last);
      ld_start = 1; ld_bank = bank; tick(); ld_start = 0;
      for (int i = 0; i < stim.size(); i++) begin
         ld_byte_valid = 1; ld_byte = stim[i];
         if (end_with_last && i == stim.size() - 1) ld_end = 1;
         tick();
      end
      ld_byte_valid = 0;
      if (!end_with_last) begin ld_end = 1; tick(); end
      ld_end = 0;
      stim.delete();
   endtask

   task automatic fetch(input logic [31:0] a);
      fetch_en = 1; pc = a; tick(); fetch_en = 0;
   endtask

   initial begin
      reset = 0; pc = 0; fetch_en = 0; stall = 0; ld_start = 0; ld_bank = 0;
      ld_byte_valid = 0; ld_byte = 0; ld_end = 0;
      tick(); tick();
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_busy", 32'(ld_busy), 32'd0);
      chk("rst_count", 32'(ld_count), 32'd0);
      reset = 1;
      tick();

      // 1: asynchronous reset mid-fetch and mid-session
      fetch(32'h8000_0002);
      chk("t1_trap", instr, 32'hFFFF_FFFF);
      ld_start = 1; ld_bank = 0; tick(); ld_start = 0;
      chk("t1_busy", 32'(ld_busy), 32'd1);
      reset = 0; #1;
      chk("t1_async_instr", instr, 32'h0);
      chk("t1_async_valid", 32'(instr_valid), 32'd0);
      chk("t1_async_busy", 32'(ld_busy), 32'd0);
      tick(); reset = 1; tick();

      // 2: user load of one word, then fetch
      stim = '{8'h40, 8'h00, 8'h08, 8'h24};
      load(0, 0);
      chk("t2_count", 32'(ld_count), 32'd1);
      chk("t2_done", 32'(ld_done), 32'd1);
      chk("t2_err", 32'(ld_err), 32'd0);
      fetch(32'h0);
      chk("t2_instr", instr, 32'h2408_0040);
      chk("t2_valid", 32'(instr_valid), 32'd1);

      // 3: kernel load of two words, fetch and trap cases
      stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(1, 0);
      fetch(32'h8000_0004);
      chk("t3_kword1", instr, 32'h8877_6655);
      fetch(32'h8000_0002);
      chk("t3_misalign", instr, 32'hFFFF_FFFF);
      fetch(32'h0000_1000);
      chk("t3_range", instr, 32'hFFFF_FFFF);
      chk("t3_range_valid", 32'(instr_valid), 32'd1);

      // 4: stall holds output, idle clears it
      fetch(32'h0);
      stall = 1; fetch_en = 1; pc = 32'h8000_0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_stall_instr", instr, 32'h2408_0040);
         chk("t4_stall_valid", 32'(instr_valid), 32'd1);
      end
      stall = 0; fetch_en = 0; tick();
      chk("t4_idle_instr", instr, 32'h0);
      chk("t4_idle_valid", 32'(instr_valid), 32'd0);

      // 5a: partial word at end
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      load(0, 0);
      stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      load(0, 0);
      chk("t5_count", 32'(ld_count), 32'd1);
      chk("t5_err", 32'(ld_err), 32'd1);
      chk("t5_done", 32'(ld_done), 32'd1);
      fetch(32'h4);
      chk("t5_word1_kept", instr, 32'h0807_0605);
      fetch(32'h0);
      chk("t5_word0", instr, 32'hA4A3_A2A1);

      // 5b: kernel overflow
      for (int i = 0; i < 129; i++) stim.push_back(8'(i));
      load(1, 0);
      chk("t5_ovf_count", 32'(ld_count), 32'd32);
      chk("t5_ovf_err", 32'(ld_err), 32'd1);
      fetch(32'h8000_007C);
      chk("t5_klast", instr, 32'h7F7E_7D7C);

      // 6: load start wins over fetch; byte 4 with end in same cycle
      ld_start = 1; ld_bank = 0; fetch_en = 1; pc = 32'h0; tick();
      ld_start = 0; fetch_en = 0;
      chk("t6_busy", 32'(ld_busy), 32'd1);
      chk("t6_valid", 32'(instr_valid), 32'd0);
      chk("t6_instr", instr, 32'h0);
      foreach (stim[i]) stim.delete(i);
      stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) begin
         ld_byte_valid = 1; ld_byte = stim[i];
         if (i == 3) ld_end = 1;
         tick();
      end
      ld_byte_valid = 0; ld_end = 0; stim.delete();
      chk("t6_err", 32'(ld_err), 32'd0);
      chk("t6_count", 32'(ld_count), 32'd1);
      chk("t6_busy_off", 32'(ld_busy), 32'd0);
      fetch(32'h0);
      chk("t6_new_word", instr, 32'hEFBE_ADDE);

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
